game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 25 ++
 rtl/game_ctrl_sat_counter.sv | 40 ++++
 rtl/game_ctrl.sv | 160 ++++++++++++++++
 tb/tb_game_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared state encoding, counter widths and judge-window constants for the rhythm-game controller.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM    = 2'd1,
      PLAY   = 2'd2,
      RESULT = 2'd3
   } state_t;

   localparam int SCORE_W  = 10;
   localparam int COMBO_W  = 8;
   localparam int MISS_W   = 10;
   localparam int OFFSET_W = 3;

   localparam logic [OFFSET_W-1:0] PERFECT_LO = 3'd2;
   localparam logic [OFFSET_W-1:0] PERFECT_HI = 3'd4;
   localparam logic [OFFSET_W-1:0] OFFSET_MAX = 3'd6;

   // A hit inside the centre window of the pixel phase is worth double.
   function automatic logic [1:0] hitPoints(input logic [OFFSET_W-1:0] phase);
      return ((phase >= PERFECT_LO) && (phase <= PERFECT_HI)) ? 2'd2 : 2'd1;
   endfunction

endpackage

// File: rtl/game_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and a small per-cycle step.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [1:0]       step_i,
   output logic [WIDTH-1:0] count_o
);

   localparam logic [WIDTH:0] MAX_VAL = {1'b0, {WIDTH{1'b1}}};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH:0]   sum;

   // One extra bit on the sum lets us detect overflow and pin at all-ones.
   always_comb begin
      sum     = {1'b0, count_q} + {{(WIDTH-1){1'b0}}, step_i};
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = (sum > MAX_VAL) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/game_ctrl.sv
// Rhythm-game controller: start/play/result sequencing, hit/miss judging and score bookkeeping.
module game_ctrl
   import game_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [1:0]          sel,
   input  logic                btn_r,
   input  logic                btn_b,
   input  logic                note_r_judge,
   input  logic                note_b_judge,
   input  logic [OFFSET_W-1:0] offset,
   input  logic                finish,
   output logic [1:0]          song,
   output logic                delete,
   output logic [SCORE_W-1:0]  score,
   output logic [COMBO_W-1:0]  combo,
   output logic [COMBO_W-1:0]  max_combo,
   output logic [MISS_W-1:0]   miss_cnt,
   output logic [1:0]          state,
   output logic                done
);

   state_t              state_q;
   state_t              state_d;
   logic [1:0]          song_q;
   logic [1:0]          song_d;
   logic                judged_q;
   logic                judged_d;
   logic                delete_q;
   logic [COMBO_W-1:0]  maxCombo_q;
   logic [COMBO_W-1:0]  maxCombo_d;
   logic [OFFSET_W-1:0] offsetPrev_q;

   logic                armEntry;
   logic                inPlay;
   logic                advance;
   logic                redHit;
   logic                blueHit;
   logic                hit;
   logic                wrongPress;
   logic                missNote;
   logic [1:0]          hitStep;

   logic [SCORE_W-1:0]  scoreCnt;
   logic [COMBO_W-1:0]  comboCnt;
   logic [MISS_W-1:0]   missCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // In PLAY, finish takes priority over an abort request arriving in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && (sel != 2'd0)) state_d = ARM;
         ARM:     state_d = PLAY;
         PLAY:    if (finish) state_d = RESULT;
                  else if (start) state_d = IDLE;
         RESULT:  if (start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Song is captured on the edge into ARM so it is already visible during ARM.
   always_comb begin
      armEntry = (state_q == IDLE) && (state_d == ARM);
      song_d   = song_q;
      if (armEntry) begin
         song_d = sel;
      end else if ((state_d == IDLE) || (state_d == RESULT)) begin
         song_d = 2'd0;
      end
   end

   always_comb begin
      inPlay     = (state_q == PLAY);
      advance    = (offsetPrev_q == OFFSET_MAX) && (offset == '0);
      redHit     = inPlay && btn_r && note_r_judge && !judged_q;
      blueHit    = inPlay && btn_b && note_b_judge && !judged_q;
      hit        = redHit || blueHit;
      wrongPress = inPlay && (btn_r || btn_b) && !hit;
      missNote   = inPlay && advance && (note_r_judge || note_b_judge) && !judged_q && !hit;
      hitStep    = hitPoints(offset);

      judged_d = judged_q;
      if (armEntry || (inPlay && advance)) begin
         judged_d = 1'b0;
      end else if (hit) begin
         judged_d = 1'b1;
      end

      // combo never exceeds max_combo, so max only moves when they are equal and combo steps up.
      maxCombo_d = maxCombo_q;
      if (armEntry) begin
         maxCombo_d = '0;
      end else if (hit && (comboCnt == maxCombo_q) && (comboCnt != '1)) begin
         maxCombo_d = maxCombo_q + COMBO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         song_q       <= 2'd0;
         judged_q     <= 1'b0;
         delete_q     <= 1'b0;
         maxCombo_q   <= '0;
         offsetPrev_q <= '0;
      end else begin
         song_q       <= song_d;
         judged_q     <= judged_d;
         delete_q     <= hit;
         maxCombo_q   <= maxCombo_d;
         offsetPrev_q <= offset;
      end
   end

   sat_counter #(.WIDTH(SCORE_W)) scoreCounter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (armEntry),
      .inc_i   (hit),
      .step_i  (hitStep),
      .count_o (scoreCnt)
   );

   sat_counter #(.WIDTH(COMBO_W)) comboCounter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (armEntry || wrongPress || missNote),
      .inc_i   (hit),
      .step_i  (2'd1),
      .count_o (comboCnt)
   );

   sat_counter #(.WIDTH(MISS_W)) missCounter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (armEntry),
      .inc_i   (missNote),
      .step_i  (2'd1),
      .count_o (missCnt)
   );

   assign song      = song_q;
   assign delete    = delete_q;
   assign score     = scoreCnt;
   assign combo     = comboCnt;
   assign max_combo = maxCombo_q;
   assign miss_cnt  = missCnt;
   assign state     = state_q;
   assign done      = (state_q == RESULT);

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a vector table for single-cycle behaviour plus
// hand-written saturation and asynchronous-reset sequences.
module tb_game_ctrl;

   typedef struct packed {
      logic       st;
      logic [1:0] sel;
      logic       r;
      logic       b;
      logic       nr;
      logic       nb;
      logic [2:0] off;
      logic       fin;
      logic [1:0] eState;
      logic [1:0] eSong;
      logic       eDel;
      logic [9:0] eScore;
      logic [7:0] eCombo;
      logic [7:0] eMax;
      logic [9:0] eMiss;
      logic       eDone;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [1:0] sel;
   logic       btnR;
   logic       btnB;
   logic       noteR;
   logic       noteB;
   logic [2:0] offset;
   logic       finish;
   logic [1:0] song;
   logic       delete;
   logic [9:0] score;
   logic [7:0] combo;
   logic [7:0] maxCombo;
   logic [9:0] missCnt;
   logic [1:0] state;
   logic       done;

   int   checkCount = 0;
   int   failCount  = 0;
   vec_t vecs[$];
   vec_t zeroVec;
   int   expScore;
   int   expCombo;

   game_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .sel          (sel),
      .btn_r        (btnR),
      .btn_b        (btnB),
      .note_r_judge (noteR),
      .note_b_judge (noteB),
      .offset       (offset),
      .finish       (finish),
      .song         (song),
      .delete       (delete),
      .score        (score),
      .combo        (combo),
      .max_combo    (maxCombo),
      .miss_cnt     (missCnt),
      .state        (state),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic st, input logic [1:0] vSel, input logic r, input logic b,
      input logic nr, input logic nb, input logic [2:0] off, input logic fin,
      input logic [1:0] eState, input logic [1:0] eSong, input logic eDel,
      input logic [9:0] eScore, input logic [7:0] eCombo, input logic [7:0] eMax,
      input logic [9:0] eMiss, input logic eDone);
      vec_t v;
      v.st = st;        v.sel = vSel;     v.r = r;           v.b = b;
      v.nr = nr;        v.nb = nb;        v.off = off;       v.fin = fin;
      v.eState = eState; v.eSong = eSong; v.eDel = eDel;     v.eScore = eScore;
      v.eCombo = eCombo; v.eMax = eMax;   v.eMiss = eMiss;   v.eDone = eDone;
      return v;
   endfunction

   function automatic vec_t drv(
      input logic st, input logic [1:0] vSel, input logic r, input logic b,
      input logic nr, input logic nb, input logic [2:0] off, input logic fin);
      return mk(st, vSel, r, b, nr, nb, off, fin, 2'd0, 2'd0, 1'b0, 10'd0, 8'd0, 8'd0, 10'd0, 1'b0);
   endfunction

   // Drive one cycle of inputs, then sample 1 time unit after the consuming edge.
   task automatic applyStimulus(input vec_t v);
      start  = v.st;
      sel    = v.sel;
      btnR   = v.r;
      btnB   = v.b;
      noteR  = v.nr;
      noteB  = v.nb;
      offset = v.off;
      finish = v.fin;
      @(posedge clk);
      #1;
   endtask

   task automatic checkValue(input string name, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic checkOutput(input string tag, input vec_t v);
      checkValue({tag, ".state"},    int'(state),    int'(v.eState));
      checkValue({tag, ".song"},     int'(song),     int'(v.eSong));
      checkValue({tag, ".delete"},   int'(delete),   int'(v.eDel));
      checkValue({tag, ".score"},    int'(score),    int'(v.eScore));
      checkValue({tag, ".combo"},    int'(combo),    int'(v.eCombo));
      checkValue({tag, ".maxCombo"}, int'(maxCombo), int'(v.eMax));
      checkValue({tag, ".missCnt"},  int'(missCnt),  int'(v.eMiss));
      checkValue({tag, ".done"},     int'(done),     int'(v.eDone));
   endtask

   initial begin
      zeroVec = '0;
      rst_n  = 1'b0;
      start  = 1'b0;
      sel    = 2'd0;
      btnR   = 1'b0;
      btnB   = 1'b0;
      noteR  = 1'b0;
      noteB  = 1'b0;
      offset = 3'd0;
      finish = 1'b0;

      //           st sel r  b  nr nb off fin | state song del score combo max miss done
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 0, 3, 0,   2, 1, 1, 2, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 0, 3, 0,   2, 1, 0, 2, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 4, 0,   2, 1, 0, 2, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 6, 0,   2, 1, 0, 2, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0,   2, 1, 0, 2, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 1, 2, 0,   2, 1, 1, 4, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 6, 0,   2, 1, 0, 4, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0,   2, 1, 0, 4, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 5, 0,   2, 1, 0, 4, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 6, 0,   2, 1, 0, 4, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0,   2, 1, 0, 4, 0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0,   2, 1, 0, 4, 0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 1, 6, 0,   2, 1, 1, 5, 1, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0,   2, 1, 0, 5, 1, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 6, 0,   2, 1, 0, 5, 1, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0,   2, 1, 1, 6, 2, 2, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0,   2, 1, 0, 6, 2, 2, 1, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 3, 0,   2, 1, 1, 8, 3, 3, 1, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0, 3, 0,   2, 1, 0, 8, 0, 3, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3, 1,   3, 0, 0, 8, 0, 3, 1, 1));
      vecs.push_back(mk(0, 1, 1, 0, 1, 0, 3, 0,   3, 0, 0, 8, 0, 3, 1, 1));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3, 0,   0, 0, 0, 8, 0, 3, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 1, 3, 0,   0, 0, 0, 8, 0, 3, 1, 0));
      vecs.push_back(mk(1, 3, 0, 0, 0, 0, 3, 0,   1, 3, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0,   2, 3, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 3, 0,   2, 3, 1, 2, 1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3, 0,   0, 0, 0, 2, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0,   0, 0, 0, 2, 1, 1, 0, 0));

      #12;
      checkOutput("reset", zeroVec);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), vecs[i]);
      end

      // Long run of perfect hits, one per column, to reach both saturation limits.
      applyStimulus(drv(1, 2, 0, 0, 0, 0, 3, 0));
      checkValue("sat.arm.state", int'(state), 1);
      checkValue("sat.arm.score", int'(score), 0);
      applyStimulus(drv(0, 2, 0, 0, 0, 0, 3, 0));
      checkValue("sat.play.state", int'(state), 2);
      for (int k = 1; k <= 513; k++) begin
         applyStimulus(drv(0, 2, 1, 0, 1, 0, 3, 0));
         if (k == 255 || k == 256 || k == 511 || k == 512 || k == 513) begin
            expScore = (2 * k > 1023) ? 1023 : 2 * k;
            expCombo = (k > 255) ? 255 : k;
            checkValue($sformatf("sat%0d.score", k),    int'(score),    expScore);
            checkValue($sformatf("sat%0d.combo", k),    int'(combo),    expCombo);
            checkValue($sformatf("sat%0d.maxCombo", k), int'(maxCombo), expCombo);
            checkValue($sformatf("sat%0d.missCnt", k),  int'(missCnt),  0);
         end
         applyStimulus(drv(0, 2, 0, 0, 1, 0, 6, 0));
         applyStimulus(drv(0, 2, 0, 0, 1, 0, 0, 0));
      end
      checkValue("sat.end.missCnt", int'(missCnt), 0);

      // Reset asserted between edges must clear outputs without waiting for a clock.
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncReset", zeroVec);
      @(posedge clk);
      #4;
      start = 1'b1;
      sel   = 2'd1;
      rst_n = 1'b1;
      #1;
      checkValue("postReset.state", int'(state), 0);
      @(posedge clk);
      #1;
      checkValue("postReset.arm", int'(state), 1);
      start = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
